exe_stage: RTL and testbench



---
 rtl/exe_stage_if.sv | 53 +++++
 rtl/exe_stage.sv | 142 ++++++++++++++
 tb/tb_exe_stage.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_stage_if.sv
// ID->EXE bundle: stage controls, decoded ID fields, and everything the EXE stage
// returns to MEM, the controller and IF. The controller/ID side is the master.
interface exe_stage_if;
    logic        exe_rst;
    logic        exe_en;
    logic        id_valid;
    logic [31:0] inst_id;
    logic [31:0] pc_id;
    logic [31:0] data_rs_id;
    logic [31:0] data_rt_id;
    logic [31:0] data_imm_id;
    logic [2:0]  pc_src_id;
    logic [1:0]  exe_a_src_id;
    logic [1:0]  exe_b_src_id;
    logic [3:0]  exe_alu_oper_id;
    logic        mem_ren_id;
    logic        mem_wen_id;
    logic        wb_data_src_id;
    logic        wb_wen_id;
    logic [1:0]  wb_addr_src_id;

    logic        exe_valid;
    logic [31:0] inst_exe;
    logic [31:0] pc_exe;
    logic [31:0] data_rt_exe;
    logic        mem_ren_exe;
    logic        mem_wen_exe;
    logic        wb_data_src_exe;
    logic        wb_wen_exe;
    logic [4:0]  regw_addr_exe;
    logic        is_branch_exe;
    logic [31:0] alu_out;
    logic        pc_redirect;
    logic [31:0] pc_target;

    modport master (
        output exe_rst, exe_en, id_valid, inst_id, pc_id, data_rs_id, data_rt_id,
               data_imm_id, pc_src_id, exe_a_src_id, exe_b_src_id, exe_alu_oper_id,
               mem_ren_id, mem_wen_id, wb_data_src_id, wb_wen_id, wb_addr_src_id,
        input  exe_valid, inst_exe, pc_exe, data_rt_exe, mem_ren_exe, mem_wen_exe,
               wb_data_src_exe, wb_wen_exe, regw_addr_exe, is_branch_exe, alu_out,
               pc_redirect, pc_target
    );

    modport slave (
        input  exe_rst, exe_en, id_valid, inst_id, pc_id, data_rs_id, data_rt_id,
               data_imm_id, pc_src_id, exe_a_src_id, exe_b_src_id, exe_alu_oper_id,
               mem_ren_id, mem_wen_id, wb_data_src_id, wb_wen_id, wb_addr_src_id,
        output exe_valid, inst_exe, pc_exe, data_rt_exe, mem_ren_exe, mem_wen_exe,
               wb_data_src_exe, wb_wen_exe, regw_addr_exe, is_branch_exe, alu_out,
               pc_redirect, pc_target
    );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: ID->EXE pipeline register, operand muxes, ALU, jump/branch
// resolution and a one-shot PC redirect that fires once per held control-flow op.
module exe_stage (
    input  logic        clk,
    input  logic        rst_n,
    exe_stage_if.slave  bus
);
    localparam logic [2:0] PC_NEXT = 3'd0, PC_JUMP = 3'd1, PC_JR = 3'd2,
                           PC_BEQ = 3'd3, PC_BNE = 3'd4;
    localparam logic [1:0] A_RS = 2'd0, A_LINK = 2'd1, A_BRANCH = 2'd2;
    localparam logic [1:0] B_RT = 2'd0, B_IMM = 2'd1, B_LINK = 2'd2, B_BRANCH = 2'd3;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                           ALU_OR = 4'd3, ALU_SLT = 4'd4;
    localparam logic [1:0] WB_RD = 2'd0, WB_RT = 2'd1, WB_LINK = 2'd2;

    logic [31:0] inst_r, pc_r, rs_r, rt_r, imm_r;
    logic [2:0]  pc_src_r;
    logic [1:0]  a_src_r, b_src_r, wb_addr_src_r;
    logic [3:0]  alu_oper_r;
    logic        mem_ren_r, mem_wen_r, wb_data_src_r, wb_wen_r;
    logic        valid_r, fired_r;

    logic [31:0] pc_plus4_s, op_a_s, op_b_s, alu_s, target_s;
    logic        take_s, redirect_s;
    logic [4:0]  regw_s;

    // Stage register: flush/bubble on reset or exe_rst, load on exe_en, else hold and arm the one-shot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r <= 32'd0; pc_r <= 32'd0; rs_r <= 32'd0; rt_r <= 32'd0; imm_r <= 32'd0;
            pc_src_r <= PC_NEXT; a_src_r <= 2'd0; b_src_r <= 2'd0; alu_oper_r <= 4'd0;
            mem_ren_r <= 1'b0; mem_wen_r <= 1'b0; wb_data_src_r <= 1'b0; wb_wen_r <= 1'b0;
            wb_addr_src_r <= 2'd0; valid_r <= 1'b0; fired_r <= 1'b0;
        end else if (bus.exe_rst || (bus.exe_en && !bus.id_valid)) begin
            inst_r <= 32'd0; pc_r <= 32'd0; rs_r <= 32'd0; rt_r <= 32'd0; imm_r <= 32'd0;
            pc_src_r <= PC_NEXT; a_src_r <= 2'd0; b_src_r <= 2'd0; alu_oper_r <= 4'd0;
            mem_ren_r <= 1'b0; mem_wen_r <= 1'b0; wb_data_src_r <= 1'b0; wb_wen_r <= 1'b0;
            wb_addr_src_r <= 2'd0; valid_r <= 1'b0; fired_r <= 1'b0;
        end else if (bus.exe_en) begin
            inst_r <= bus.inst_id; pc_r <= bus.pc_id; rs_r <= bus.data_rs_id;
            rt_r <= bus.data_rt_id; imm_r <= bus.data_imm_id;
            pc_src_r <= bus.pc_src_id; a_src_r <= bus.exe_a_src_id;
            b_src_r <= bus.exe_b_src_id; alu_oper_r <= bus.exe_alu_oper_id;
            mem_ren_r <= bus.mem_ren_id; mem_wen_r <= bus.mem_wen_id;
            wb_data_src_r <= bus.wb_data_src_id; wb_wen_r <= bus.wb_wen_id;
            wb_addr_src_r <= bus.wb_addr_src_id; valid_r <= 1'b1; fired_r <= 1'b0;
        end else if (redirect_s) begin
            fired_r <= 1'b1;
        end else begin
            fired_r <= fired_r;
        end
    end

    assign pc_plus4_s = pc_r + 32'd4;

    // Operand muxes and ALU.
    always_comb begin
        op_a_s = 32'd0;
        op_b_s = 32'd0;
        alu_s  = 32'd0;
        case (a_src_r)
            A_RS:     op_a_s = rs_r;
            A_LINK:   op_a_s = pc_r;
            A_BRANCH: op_a_s = pc_plus4_s;
            default:  op_a_s = 32'd0;
        endcase
        case (b_src_r)
            B_RT:     op_b_s = rt_r;
            B_IMM:    op_b_s = imm_r;
            B_LINK:   op_b_s = 32'd4;
            B_BRANCH: op_b_s = {imm_r[29:0], 2'b00};
            default:  op_b_s = 32'd0;
        endcase
        case (alu_oper_r)
            ALU_ADD: alu_s = op_a_s + op_b_s;
            ALU_SUB: alu_s = op_a_s - op_b_s;
            ALU_AND: alu_s = op_a_s & op_b_s;
            ALU_OR:  alu_s = op_a_s | op_b_s;
            ALU_SLT: alu_s = ($signed(op_a_s) < $signed(op_b_s)) ? 32'd1 : 32'd0;
            default: alu_s = 32'd0;
        endcase
    end

    // Control-flow resolution: target is always computed, take only for a valid instruction.
    always_comb begin
        take_s   = 1'b0;
        target_s = 32'd0;
        case (pc_src_r)
            PC_JUMP: begin
                target_s = {pc_plus4_s[31:28], inst_r[25:0], 2'b00};
                take_s   = valid_r;
            end
            PC_JR: begin
                target_s = rs_r;
                take_s   = valid_r;
            end
            PC_BEQ: begin
                target_s = alu_s;
                take_s   = valid_r && (rs_r == rt_r);
            end
            PC_BNE: begin
                target_s = alu_s;
                take_s   = valid_r && (rs_r != rt_r);
            end
            default: begin
                target_s = 32'd0;
                take_s   = 1'b0;
            end
        endcase
    end

    // Write-back register address, zeroed for bubbles so hazard logic never matches them.
    always_comb begin
        regw_s = 5'd0;
        if (valid_r) begin
            case (wb_addr_src_r)
                WB_RD:   regw_s = inst_r[15:11];
                WB_RT:   regw_s = inst_r[20:16];
                WB_LINK: regw_s = 5'd31;
                default: regw_s = 5'd0;
            endcase
        end else begin
            regw_s = 5'd0;
        end
    end

    assign redirect_s          = take_s && !fired_r;

    assign bus.exe_valid       = valid_r;
    assign bus.inst_exe        = inst_r;
    assign bus.pc_exe          = pc_r;
    assign bus.data_rt_exe     = rt_r;
    assign bus.mem_ren_exe     = mem_ren_r;
    assign bus.mem_wen_exe     = mem_wen_r;
    assign bus.wb_data_src_exe = wb_data_src_r;
    assign bus.wb_wen_exe      = wb_wen_r && valid_r;
    assign bus.regw_addr_exe   = regw_s;
    assign bus.is_branch_exe   = valid_r && (pc_src_r != PC_NEXT);
    assign bus.alu_out         = alu_s;
    assign bus.pc_redirect     = redirect_s;
    assign bus.pc_target       = target_s;
endmodule

// File: tb/tb_exe_stage.sv
// Randomized + directed bench for exe_stage. Stimulus pushes the expected output of
// every cycle into a scoreboard queue; a negedge monitor pops and compares.
module tb_exe_stage;
    typedef struct packed {
        logic [31:0] inst, pc, rs, rt, imm;
        logic [2:0]  pc_src;
        logic [1:0]  a_src, b_src;
        logic [3:0]  alu_op;
        logic        mem_ren, mem_wen, wb_data_src, wb_wen;
        logic [1:0]  wb_addr_src;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst, pc, rt;
        logic        mem_ren, mem_wen, wb_data_src, wb_wen;
        logic [4:0]  regw;
        logic        is_branch;
        logic [31:0] alu;
        logic        redirect;
        logic [31:0] target;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exe_stage_if bus();

    exe_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    exp_t sb_q[$];

    // Reference model state: the instruction currently in EXE and whether it already redirected.
    instr_t m_s = '0;
    logic   m_v = 1'b0;
    logic   m_issued = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_out(input instr_t s, input logic v, input logic issued);
        exp_t e;
        logic [31:0] a, b;
        logic take;
        e = '0;
        if (s.a_src == 2'd0) a = s.rs;
        else if (s.a_src == 2'd1) a = s.pc;
        else if (s.a_src == 2'd2) a = s.pc + 32'd4;
        else a = 32'd0;
        if (s.b_src == 2'd0) b = s.rt;
        else if (s.b_src == 2'd1) b = s.imm;
        else if (s.b_src == 2'd2) b = 32'd4;
        else b = s.imm * 32'd4;
        if (s.alu_op == 4'd0) e.alu = a + b;
        else if (s.alu_op == 4'd1) e.alu = a - b;
        else if (s.alu_op == 4'd2) e.alu = a & b;
        else if (s.alu_op == 4'd3) e.alu = a | b;
        else if (s.alu_op == 4'd4) e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        else e.alu = 32'd0;
        take = 1'b0;
        e.target = 32'd0;
        if (s.pc_src == 3'd1) begin
            e.target = ((s.pc + 32'd4) & 32'hF000_0000) | ((s.inst & 32'h03FF_FFFF) * 32'd4);
            take = 1'b1;
        end else if (s.pc_src == 3'd2) begin
            e.target = s.rs; take = 1'b1;
        end else if (s.pc_src == 3'd3) begin
            e.target = e.alu; take = (s.rs == s.rt);
        end else if (s.pc_src == 3'd4) begin
            e.target = e.alu; take = (s.rs != s.rt);
        end
        e.valid       = v;
        e.inst        = s.inst;
        e.pc          = s.pc;
        e.rt          = s.rt;
        e.mem_ren     = s.mem_ren;
        e.mem_wen     = s.mem_wen;
        e.wb_data_src = s.wb_data_src;
        e.wb_wen      = s.wb_wen && v;
        if (!v) e.regw = 5'd0;
        else if (s.wb_addr_src == 2'd0) e.regw = 5'(s.inst >> 11);
        else if (s.wb_addr_src == 2'd1) e.regw = 5'(s.inst >> 16);
        else if (s.wb_addr_src == 2'd2) e.regw = 5'd31;
        else e.regw = 5'd0;
        e.is_branch = v && (s.pc_src != 3'd0);
        e.redirect  = v && take && !issued;
        return e;
    endfunction

    // Drive one cycle of stimulus, advance the model at the edge, push the expected outputs.
    task automatic step(input instr_t i, input logic v, input logic en, input logic rst);
        exp_t cur;
        bus.exe_rst = rst; bus.exe_en = en; bus.id_valid = v;
        bus.inst_id = i.inst; bus.pc_id = i.pc; bus.data_rs_id = i.rs;
        bus.data_rt_id = i.rt; bus.data_imm_id = i.imm; bus.pc_src_id = i.pc_src;
        bus.exe_a_src_id = i.a_src; bus.exe_b_src_id = i.b_src;
        bus.exe_alu_oper_id = i.alu_op; bus.mem_ren_id = i.mem_ren;
        bus.mem_wen_id = i.mem_wen; bus.wb_data_src_id = i.wb_data_src;
        bus.wb_wen_id = i.wb_wen; bus.wb_addr_src_id = i.wb_addr_src;
        @(posedge clk);
        cur = model_out(m_s, m_v, m_issued);
        if (rst || (en && !v)) begin
            m_s = '0; m_v = 1'b0; m_issued = 1'b0;
        end else if (en) begin
            m_s = i; m_v = 1'b1; m_issued = 1'b0;
        end else if (cur.redirect) begin
            m_issued = 1'b1;
        end
        sb_q.push_back(model_out(m_s, m_v, m_issued));
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".valid"},     32'(bus.exe_valid), 32'd0);
        chk({tag, ".inst"},      bus.inst_exe, 32'd0);
        chk({tag, ".pc"},        bus.pc_exe, 32'd0);
        chk({tag, ".rt"},        bus.data_rt_exe, 32'd0);
        chk({tag, ".mem"},       32'({bus.mem_ren_exe, bus.mem_wen_exe, bus.wb_data_src_exe}), 32'd0);
        chk({tag, ".wb_wen"},    32'(bus.wb_wen_exe), 32'd0);
        chk({tag, ".regw"},      32'(bus.regw_addr_exe), 32'd0);
        chk({tag, ".is_branch"}, 32'(bus.is_branch_exe), 32'd0);
        chk({tag, ".alu"},       bus.alu_out, 32'd0);
        chk({tag, ".redirect"},  32'(bus.pc_redirect), 32'd0);
        chk({tag, ".target"},    bus.pc_target, 32'd0);
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        i.inst        = $urandom;
        i.pc          = $urandom & 32'hFFFF_FFFC;
        i.rs          = $urandom;
        i.rt          = ($urandom_range(1, 0) == 1) ? i.rs : $urandom;
        i.imm         = $urandom;
        i.pc_src      = 3'($urandom_range(4, 0));
        i.a_src       = 2'($urandom_range(2, 0));
        i.b_src       = 2'($urandom_range(3, 0));
        i.alu_op      = 4'($urandom_range(5, 0));
        i.mem_ren     = 1'($urandom_range(1, 0));
        i.mem_wen     = 1'($urandom_range(1, 0));
        i.wb_data_src = 1'($urandom_range(1, 0));
        i.wb_wen      = 1'($urandom_range(1, 0));
        i.wb_addr_src = 2'($urandom_range(2, 0));
        return i;
    endfunction

    // Monitor: compare DUT outputs with the oldest expected record every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("valid",     32'(bus.exe_valid), 32'(e.valid));
            chk("inst",      bus.inst_exe, e.inst);
            chk("pc",        bus.pc_exe, e.pc);
            chk("data_rt",   bus.data_rt_exe, e.rt);
            chk("mem_ren",   32'(bus.mem_ren_exe), 32'(e.mem_ren));
            chk("mem_wen",   32'(bus.mem_wen_exe), 32'(e.mem_wen));
            chk("wb_src",    32'(bus.wb_data_src_exe), 32'(e.wb_data_src));
            chk("wb_wen",    32'(bus.wb_wen_exe), 32'(e.wb_wen));
            chk("regw",      32'(bus.regw_addr_exe), 32'(e.regw));
            chk("is_branch", 32'(bus.is_branch_exe), 32'(e.is_branch));
            chk("alu_out",   bus.alu_out, e.alu);
            chk("redirect",  32'(bus.pc_redirect), 32'(e.redirect));
            if (e.redirect) chk("pc_target", bus.pc_target, e.target);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        instr_t i;
        int pulses;
        bus.exe_rst = 1'b0; bus.exe_en = 1'b0; bus.id_valid = 1'b0;
        bus.inst_id = 32'd0; bus.pc_id = 32'd0; bus.data_rs_id = 32'd0;
        bus.data_rt_id = 32'd0; bus.data_imm_id = 32'd0; bus.pc_src_id = 3'd0;
        bus.exe_a_src_id = 2'd0; bus.exe_b_src_id = 2'd0; bus.exe_alu_oper_id = 4'd0;
        bus.mem_ren_id = 1'b0; bus.mem_wen_id = 1'b0; bus.wb_data_src_id = 1'b0;
        bus.wb_wen_id = 1'b0; bus.wb_addr_src_id = 2'd0;

        // Reset state, then release: stays a bubble until exe_en.
        #12 check_zero("reset");
        rst_n = 1'b1;
        i = rand_instr();
        step(i, 1'b1, 1'b0, 1'b0);
        step(i, 1'b1, 1'b0, 1'b0);
        check_zero("idle");

        // ADD rs=5 rt=7 -> rd=3.
        i = '0; i.rs = 32'd5; i.rt = 32'd7; i.inst = 32'd3 << 11; i.wb_wen = 1'b1;
        step(i, 1'b1, 1'b1, 1'b0);
        chk("add.alu", bus.alu_out, 32'd12);
        chk("add.regw", 32'(bus.regw_addr_exe), 32'd3);
        chk("add.wb_wen", 32'(bus.wb_wen_exe), 32'd1);

        // BEQ taken, then held one cycle: one pulse to 0x114.
        i = '0; i.pc = 32'h100; i.rs = 32'd9; i.rt = 32'd9; i.imm = 32'd4;
        i.pc_src = 3'd3; i.a_src = 2'd2; i.b_src = 2'd3;
        step(i, 1'b1, 1'b1, 1'b0);
        chk("beq.redirect", 32'(bus.pc_redirect), 32'd1);
        chk("beq.target", bus.pc_target, 32'h114);
        step(i, 1'b1, 1'b0, 1'b0);
        chk("beq.held", 32'(bus.pc_redirect), 32'd0);

        // BEQ not taken still reports a branch.
        i.rt = 32'd8;
        step(i, 1'b1, 1'b1, 1'b0);
        chk("bnt.redirect", 32'(bus.pc_redirect), 32'd0);
        chk("bnt.is_branch", 32'(bus.is_branch_exe), 32'd1);

        // JAL at 0x200 held three cycles: exactly one pulse.
        i = '0; i.pc = 32'h200; i.inst = 32'h0C00_0040; i.pc_src = 3'd1;
        i.a_src = 2'd1; i.b_src = 2'd2; i.wb_wen = 1'b1; i.wb_addr_src = 2'd2;
        step(i, 1'b1, 1'b1, 1'b0);
        pulses = int'(bus.pc_redirect);
        chk("jal.alu", bus.alu_out, 32'h204);
        chk("jal.regw", 32'(bus.regw_addr_exe), 32'd31);
        chk("jal.target", bus.pc_target, 32'h100);
        for (int k = 0; k < 3; k++) begin
            step(i, 1'b1, 1'b0, 1'b0);
            pulses += int'(bus.pc_redirect);
        end
        chk("jal.pulses", 32'(pulses), 32'd1);

        // SLT -1 < 1, SUB 0-1.
        i = '0; i.rs = 32'hFFFF_FFFF; i.rt = 32'd1; i.alu_op = 4'd4;
        step(i, 1'b1, 1'b1, 1'b0);
        chk("slt.alu", bus.alu_out, 32'd1);
        i = '0; i.rt = 32'd1; i.alu_op = 4'd1;
        step(i, 1'b1, 1'b1, 1'b0);
        chk("sub.alu", bus.alu_out, 32'hFFFF_FFFF);

        // Flush beats enable.
        i = '0; i.inst = 32'd5 << 11; i.wb_wen = 1'b1; i.rs = 32'd3;
        step(i, 1'b1, 1'b1, 1'b1);
        chk("flush.valid", 32'(bus.exe_valid), 32'd0);
        chk("flush.wb_wen", 32'(bus.wb_wen_exe), 32'd0);
        chk("flush.regw", 32'(bus.regw_addr_exe), 32'd0);

        // Async reset while a redirect is pending: outputs clear before the next edge.
        i = '0; i.pc = 32'h300; i.pc_src = 3'd2; i.rs = 32'h400; i.wb_wen = 1'b1;
        step(i, 1'b1, 1'b1, 1'b0);
        chk("jr.redirect", 32'(bus.pc_redirect), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_zero("async");
        sb_q.delete();
        m_s = '0; m_v = 1'b0; m_issued = 1'b0;
        sb_q.push_back(model_out(m_s, m_v, m_issued));
        #1 rst_n = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(rand_instr(), ($urandom_range(9, 0) < 8), ($urandom_range(9, 0) < 7),
                 ($urandom_range(9, 0) == 0));
        end

        @(negedge clk);
        #1;
        chk("sb.drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
